// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample-slot scheduler.
// Holds the FSM encoding, source indices and default clock/sample rates.
package audio_pkg;

    localparam int unsigned DEF_CLK_HZ    = 100_000_000;
    localparam int unsigned DEF_SAMPLE_HZ = 20_000;

    localparam logic [1:0] SRC_TONE   = 2'd0;
    localparam logic [1:0] SRC_MIC    = 2'd1;
    localparam logic [1:0] SRC_PLAYER = 2'd2;
    localparam logic [1:0] SRC_TEST   = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sched_state_t;

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = SRC_TONE;
        if (oh[1]) idx = SRC_MIC;
        if (oh[2]) idx = SRC_PLAYER;
        if (oh[3]) idx = SRC_TEST;
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first requester after last_winner in order 0->1->2->3->0.
// Latency: combinational. Backpressure: none, one-hot winner or zero when no request.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last_winner,
    output logic [3:0] winner
);

    always_comb begin
        logic [1:0] idx;
        logic       found;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_winner + 2'(i);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_sched.sv
// Sample-rate divider plus round-robin slot grant; miss counter under SAMPLE_SCHED_MISS_CNT_EN.
// Latency: gnt valid one cycle after sample_tick, cleared one cycle after ack/timeout/en drop.
// Backpressure: a grant is held until ack of the granted bit or TIMEOUT cycles, whichever first.
module sample_sched
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned SAMPLE_HZ = DEF_SAMPLE_HZ,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic [3:0] ack,
    output logic       clk20k,
    output logic       sample_tick,
    output logic [3:0] gnt,
    output logic [7:0] miss_cnt
);

    localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned HW  = $clog2(TIMEOUT + 1);

    logic [CW-1:0] phase;
    sched_state_t  state;
    logic [1:0]    last_winner;
    logic [HW-1:0] hold;
    logic [3:0]    pick;
    logic          ack_hit;
    logic          timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= '0;
            clk20k <= 1'b0;
        end else begin
            clk20k <= (phase >= CW'(DIV / 2));
            if (!en || phase == CW'(DIV - 1))
                phase <= '0;
            else
                phase <= phase + CW'(1);
        end
    end

    assign sample_tick = en && (phase == CW'(DIV - 1));

    rr_pick4 u_pick (
        .req         (req),
        .last_winner (last_winner),
        .winner      (pick)
    );

    // ack wins over a coinciding timeout, so the miss is only taken when no ack landed
    assign ack_hit     = |(ack & gnt);
    assign timeout_hit = (state == ST_GRANT) && en && !ack_hit && (hold == HW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            last_winner <= SRC_TEST;
            hold        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample_tick && |req) begin
                        state <= ST_GRANT;
                        gnt   <= pick;
                        hold  <= HW'(1);
                    end
                end
                ST_GRANT: begin
                    if (ack_hit || timeout_hit) begin
                        state       <= ST_IDLE;
                        gnt         <= '0;
                        last_winner <= onehot_idx(gnt);
                    end else if (!en) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
            endcase
        end
    end

`ifdef SAMPLE_SCHED_MISS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            miss_cnt <= '0;
        else if (timeout_hit && miss_cnt != 8'hFF)
            miss_cnt <= miss_cnt + 8'd1;
    end
`else
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_sched.sv
// Bench for sample_sched with a scaled divider (DIV=100, TIMEOUT=40) and a time-based reference model.
module tb_sample_sched;

    localparam int CLK_HZ    = 2_000_000;
    localparam int SAMPLE_HZ = 20_000;
    localparam int TIMEOUT   = 40;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
`ifdef SAMPLE_SCHED_MISS_CNT_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] ack;
    logic       clk20k;
    logic       sample_tick;
    logic [3:0] gnt;
    logic [7:0] miss_cnt;

    sample_sched #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .ack         (ack),
        .clk20k      (clk20k),
        .sample_tick (sample_tick),
        .gnt         (gnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: time since enable, granted source and the edge it was granted on.
    int m_run, m_g, m_gstart, m_lw, m_miss, cyc;
    bit m_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            if (n_fail <= 30)
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_gnt();
        logic [3:0] v;
        v = '0;
        if (m_g >= 0) v[m_g] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_g = -1; m_gstart = 0; m_lw = 3; m_miss = 0; m_clk = 1'b0;
    endtask

    task automatic model_edge();
        int  ph;
        bit  tick;
        ph   = m_run % DIV;
        tick = en && (ph == DIV - 1);
        cyc++;
        m_clk = (ph >= DIV / 2);
        if (m_g >= 0) begin
            if (ack[m_g]) begin
                m_lw = m_g; m_g = -1;
            end else if (!en) begin
                m_g = -1;
            end else if (cyc - m_gstart == TIMEOUT) begin
                m_lw = m_g; m_g = -1;
                if (MISS_EN && m_miss < 255) m_miss++;
            end
        end else if (tick && req != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_g < 0 && req[(m_lw + k) % 4]) m_g = (m_lw + k) % 4;
            end
            m_gstart = cyc;
        end
        m_run = en ? m_run + 1 : 0;
    endtask

    task automatic check_outputs();
        chk("gnt", 32'(gnt), 32'(m_gnt()));
        chk("sample_tick", 32'(sample_tick), 32'(en && (m_run % DIV == DIV - 1)));
        chk("clk20k", 32'(clk20k), 32'(m_clk));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_grant(input int limit);
        for (int i = 0; i < limit && m_g < 0; i++) cycle();
    endtask

    logic [3:0] order_q[$];
    logic [3:0] prev_gnt;
    int         n_tick, n_hi, n_on, miss_before;

    initial begin
        cyc = 0;
        model_reset();
        rst_n = 1'b0; en = 1'b0; req = '0; ack = '0;
        #1;
        check_outputs();
        @(negedge clk) rst_n = 1'b1;

        // Idle divider: tick every DIV, clk20k half low / half high, no grant
        en = 1'b1;
        n_tick = 0; n_hi = 0;
        repeat (3 * DIV) begin
            cycle();
            n_tick += int'(sample_tick);
            n_hi   += int'(clk20k);
        end
        chk("tick_count", 32'(n_tick), 32'd3);
        chk("clk20k_high", 32'(n_hi), 32'(3 * DIV / 2));

        // All request, ack 10 cycles after grant: round-robin rotation
        req = 4'b1111; prev_gnt = '0;
        repeat (5 * DIV + 20) begin
            cycle();
            if (gnt != prev_gnt && gnt != 4'b0) order_q.push_back(gnt);
            prev_gnt = gnt;
            ack = (m_g >= 0 && cyc - m_gstart == 10) ? m_gnt() : 4'b0;
        end
        ack = '0;
        chk("rr_len", 32'(order_q.size()), 32'd5);
        if (order_q.size() == 5) begin
            chk("rr_0", 32'(order_q[0]), 32'b0001);
            chk("rr_1", 32'(order_q[1]), 32'b0010);
            chk("rr_2", 32'(order_q[2]), 32'b0100);
            chk("rr_3", 32'(order_q[3]), 32'b1000);
            chk("rr_4", 32'(order_q[4]), 32'b0001);
        end

        // Wrong-bit ack is ignored, matching ack releases without a miss
        req = 4'b0001;
        wait_grant(2 * DIV);
        chk("w33_gnt", 32'(gnt), 32'b0001);
        miss_before = int'(miss_cnt);
        ack = 4'b0010; cycle(); ack = '0; cycle();
        chk("w33_wrong_ack", 32'(gnt), 32'b0001);
        ack = 4'b0001; cycle(); ack = '0;
        chk("w33_ack_clear", 32'(gnt), 32'b0000);
        chk("w33_miss", 32'(miss_cnt), 32'(miss_before));

        // Enable drop during a grant releases it with no miss
        req = 4'b0010;
        wait_grant(2 * DIV);
        repeat (5) cycle();
        miss_before = int'(miss_cnt);
        en = 1'b0; cycle();
        chk("en_drop_gnt", 32'(gnt), 32'b0000);
        chk("en_drop_miss", 32'(miss_cnt), 32'(miss_before));
        repeat (3) cycle();
        en = 1'b1;

        // Randomized requests, stray acks and occasional enable drops
        repeat (25 * DIV) begin
            req = 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            en  = ($urandom_range(0, 399) != 0);
            cycle();
        end
        en = 1'b1; ack = '0;

        // Ack racing the timeout edge counts as ack
        req = 4'b1000;
        for (int i = 0; i < 3 * DIV && !(m_g >= 0 && cyc - m_gstart == TIMEOUT - 1); i++) cycle();
        miss_before = int'(miss_cnt);
        ack = m_gnt(); cycle(); ack = '0;
        chk("ack_at_timeout_gnt", 32'(gnt), 32'b0000);
        chk("ack_at_timeout_miss", 32'(miss_cnt), 32'(miss_before));

        // Single requester, no ack: timeout-length grant and saturating misses
        req = 4'b0100;
        repeat (DIV) cycle();
        n_on = 0;
        repeat (DIV) begin
            cycle();
            n_on += int'(gnt == 4'b0100);
        end
        chk("timeout_len", 32'(n_on), 32'(TIMEOUT));
        repeat (300 * DIV) cycle();
        chk("miss_sat", 32'(miss_cnt), MISS_EN ? 32'd255 : 32'd0);

        // Asynchronous reset mid-grant at phase 24, then source 0 wins first
        req = 4'b1111;
        wait_grant(2 * DIV);
        for (int i = 0; i < DIV && (m_run % DIV) != 24; i++) cycle();
        chk("pre_rst_gnt_live", 32'(gnt != 4'b0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);
        chk("rst_clk20k", 32'(clk20k), 32'd0);
        chk("rst_tick", 32'(sample_tick), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        wait_grant(2 * DIV);
        chk("post_rst_first", 32'(gnt), 32'b0001);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
